// File: rtl/alarm_seg7_scan.sv
// Scans the current time (AN[3:0]) and alarm setpoint (AN[7:4]) onto an 8-digit multiplexed 7-segment display.
// Digits come from a per-frame snapshot, so a frame is never torn; alarm digits blink while ringing.
module alarm_seg7_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD     = 4,
  parameter int BLINK_DIV = 25000000,
  parameter int BLANK_LZ  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic [3:0] hourdec_bud,
  input  logic [3:0] hourone_bud,
  input  logic [3:0] mindec_bud,
  input  logic [3:0] minone_bud,
  input  logic       bud_state,
  input  logic       sec_tick,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an,
  output logic [2:0] slot
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GUARD_V    = SW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    slot_q, slot_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          colon_q, colon_d;
  logic [3:0]    shadow_q [8];
  logic [3:0]    shadow_d [8];
  logic [3:0]    digit_in [8];
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          scan_wrap;
  logic          frame_wrap;
  logic          in_guard;
  logic [3:0]    cur_digit;
  logic          blank_lz;
  logic          blank_blink;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Slot order: minutes-ones first, alarm group in the upper four slots.
  always_comb begin
    digit_in[0] = minone_now;
    digit_in[1] = mindec_now;
    digit_in[2] = hourone_now;
    digit_in[3] = hourdec_now;
    digit_in[4] = minone_bud;
    digit_in[5] = mindec_bud;
    digit_in[6] = hourone_bud;
    digit_in[7] = hourdec_bud;
  end

  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    frame_wrap = scan_wrap && (slot_q == 3'd7);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    slot_d     = scan_wrap ? slot_q + 3'd1 : slot_q;

    for (int i = 0; i < 8; i++) begin
      shadow_d[i] = frame_wrap ? digit_in[i] : shadow_q[i];
    end

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!bud_state) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    colon_d = colon_q ^ sec_tick;
  end

  // Output stage: guard window and en=0 both force the display dark.
  always_comb begin
    in_guard    = (scan_cnt_q < GUARD_V);
    cur_digit   = shadow_q[slot_q];
    blank_lz    = (BLANK_LZ != 0) && (slot_q[1:0] == 2'b11) && (cur_digit == 4'd0);
    blank_blink = slot_q[2] && !blink_on_q;

    an_d  = 8'hFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (en && !in_guard) begin
      an_d  = ~(8'b1 << slot_q);
      seg_d = (blank_lz || blank_blink) ? SEG_OFF : decode(cur_digit);
      dp_d  = (slot_q == 3'd2) ? ~colon_q : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      slot_q      <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      colon_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
      end
      an_q  <= 8'hFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      slot_q      <= slot_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      colon_q     <= colon_d;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign slot = slot_q;

endmodule

// File: tb/tb_alarm_seg7_scan.sv
// Directed bench for alarm_seg7_scan: table of scan vectors after reset, then hand sequences
// for snapshot, colon, dash, blink, enable and mid-run reset.
module tb_alarm_seg7_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
  logic       bud_state;
  logic       sec_tick;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic [2:0] slot;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alarm_seg7_scan #(
    .SCAN_DIV (4),
    .GUARD    (1),
    .BLINK_DIV(64),
    .BLANK_LZ (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hourdec_now(hourdec_now),
    .hourone_now(hourone_now),
    .mindec_now (mindec_now),
    .minone_now (minone_now),
    .hourdec_bud(hourdec_bud),
    .hourone_bud(hourone_bud),
    .mindec_bud (mindec_bud),
    .minone_bud (minone_bud),
    .bud_state  (bud_state),
    .sec_tick   (sec_tick),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .slot       (slot)
  );

  typedef struct {
    int         k;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] slot;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stops right after slot changes to s (state scan_cnt=0, output still from the previous slot).
  task automatic wait_enter(input logic [2:0] s);
    int budget = 0;
    while (slot == s && budget < 80) begin step(1); budget++; end
    while (slot != s && budget < 80) begin step(1); budget++; end
    if (budget >= 80) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_slot%0d: timeout, slot=%0d", s, slot);
    end
  endtask

  task automatic wait_lit(input logic [2:0] s);
    wait_enter(s);
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int kcur;
    int dark_lit;
    int slot_moves;
    logic [2:0] prev_slot;

    // After-reset frame 1 (shadows 0) then frame 2 (now=12:34, bud=07:05).
    vecs[0]  = '{k: 1,  an: 8'hFF, seg: 7'h7F, dp: 1'b1, slot: 3'd0};
    vecs[1]  = '{k: 2,  an: 8'hFE, seg: 7'h40, dp: 1'b1, slot: 3'd0};
    vecs[2]  = '{k: 5,  an: 8'hFF, seg: 7'h7F, dp: 1'b1, slot: 3'd1};
    vecs[3]  = '{k: 6,  an: 8'hFD, seg: 7'h40, dp: 1'b1, slot: 3'd1};
    vecs[4]  = '{k: 14, an: 8'hF7, seg: 7'h7F, dp: 1'b1, slot: 3'd3};
    vecs[5]  = '{k: 22, an: 8'hDF, seg: 7'h40, dp: 1'b1, slot: 3'd5};
    vecs[6]  = '{k: 30, an: 8'h7F, seg: 7'h7F, dp: 1'b1, slot: 3'd7};
    vecs[7]  = '{k: 33, an: 8'hFF, seg: 7'h7F, dp: 1'b1, slot: 3'd0};
    vecs[8]  = '{k: 34, an: 8'hFE, seg: 7'h19, dp: 1'b1, slot: 3'd0};
    vecs[9]  = '{k: 38, an: 8'hFD, seg: 7'h30, dp: 1'b1, slot: 3'd1};
    vecs[10] = '{k: 42, an: 8'hFB, seg: 7'h24, dp: 1'b1, slot: 3'd2};
    vecs[11] = '{k: 46, an: 8'hF7, seg: 7'h79, dp: 1'b1, slot: 3'd3};
    vecs[12] = '{k: 50, an: 8'hEF, seg: 7'h12, dp: 1'b1, slot: 3'd4};
    vecs[13] = '{k: 54, an: 8'hDF, seg: 7'h40, dp: 1'b1, slot: 3'd5};
    vecs[14] = '{k: 58, an: 8'hBF, seg: 7'h78, dp: 1'b1, slot: 3'd6};
    vecs[15] = '{k: 62, an: 8'h7F, seg: 7'h7F, dp: 1'b1, slot: 3'd7};
    vecs[16] = '{k: 65, an: 8'hFF, seg: 7'h7F, dp: 1'b1, slot: 3'd0};

    rst = 1'b1; en = 1'b1; bud_state = 1'b0; sec_tick = 1'b0;
    hourdec_now = 4'd1; hourone_now = 4'd2; mindec_now = 4'd3; minone_now = 4'd4;
    hourdec_bud = 4'd0; hourone_bud = 4'd7; mindec_bud = 4'd0; minone_bud = 4'd5;

    step(3);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_slot", slot, 3'd0);

    @(negedge clk);
    rst = 1'b0;
    kcur = 0;
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].k - kcur);
      kcur = vecs[i].k;
      chk($sformatf("vec%0d_an", i), an, vecs[i].an);
      chk($sformatf("vec%0d_seg", i), seg, vecs[i].seg);
      chk($sformatf("vec%0d_dp", i), dp, vecs[i].dp);
      chk($sformatf("vec%0d_slot", i), slot, vecs[i].slot);
    end

    // Snapshot: changes mid-frame only show after the next 7->0 wrap.
    step(1);
    chk("snap_slot0_lit", an, 8'hFE);
    mindec_now = 4'd9;
    wait_lit(3'd1);
    chk("snap_old_mindec", seg, 7'h30);
    wait_lit(3'd2);
    minone_now = 4'd5;
    wait_lit(3'd0);
    chk("snap_new_minone", seg, 7'h12);
    wait_lit(3'd1);
    chk("snap_new_mindec", seg, 7'h10);

    // Value present in the wrap cycle is captured; a change right after the wrap is not.
    wait_enter(3'd7);
    step(3);
    hourone_now = 4'd8;
    step(1);
    hourone_now = 4'd6;
    wait_lit(3'd2);
    chk("wrap_capture", seg, 7'h00);
    wait_lit(3'd2);
    chk("wrap_next_frame", seg, 7'h02);

    // Colon on slot 2 only.
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    wait_lit(3'd2);
    chk("colon_an", an, 8'hFB);
    chk("colon_dp_on", dp, 1'b0);
    wait_lit(3'd3);
    chk("colon_dp_slot3", dp, 1'b1);
    wait_enter(3'd1);
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    wait_lit(3'd2);
    chk("colon_dp_off", dp, 1'b1);

    // Non-BCD digit shows a dash.
    hourone_now = 4'hC;
    wait_lit(3'd2);
    wait_lit(3'd2);
    chk("dash_seg", seg, 7'h3F);

    // Blink: 64 cycles visible, 64 dark, 64 visible; anodes keep scanning.
    bud_state = 1'b1;
    dark_lit = 0;
    for (int j = 1; j <= 192; j++) begin
      step(1);
      if (an[7:4] != 4'hF) begin
        if (((j - 1) / 64) % 2 == 1) begin
          dark_lit++;
          chk($sformatf("blink_dark_j%0d", j), seg, 7'h7F);
        end else if (an != 8'h7F) begin
          chk($sformatf("blink_vis_j%0d", j), (seg != 7'h7F), 1'b1);
        end
      end
    end
    chk("blink_scan_dark", (dark_lit > 0), 1'b1);
    bud_state = 1'b0;
    wait_lit(3'd4);
    chk("blink_release", seg, 7'h12);

    // en=0: outputs dark, scan keeps moving.
    en = 1'b0;
    slot_moves = 0;
    prev_slot = slot;
    for (int j = 0; j < 40; j++) begin
      step(1);
      chk("en0_an", an, 8'hFF);
      chk("en0_seg", seg, 7'h7F);
      chk("en0_dp", dp, 1'b1);
      if (slot != prev_slot) slot_moves++;
      prev_slot = slot;
    end
    chk("en0_slot_moves", slot_moves, 10);
    en = 1'b1;
    wait_lit(3'd3);
    chk("en1_an", an, 8'hF7);
    chk("en1_seg", seg, 7'h79);

    // Asynchronous reset mid-frame.
    wait_lit(3'd5);
    chk("pre_rst_an", an, 8'hDF);
    rst = 1'b1;
    #1;
    chk("mid_rst_an", an, 8'hFF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dp", dp, 1'b1);
    chk("mid_rst_slot", slot, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    step(2);
    chk("post_rst_an", an, 8'hFE);
    chk("post_rst_seg", seg, 7'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
